uart_rx_deserializer: RTL and testbench

//  UART receive stage: the downstream counterpart of the UART transmitter on the serial link.

---
 rtl/uart_rx_deserializer.sv | 215 +++++++++++++++++++++
 tb/tb_uart_rx_deserializer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_deserializer.sv
`default_nettype none
// uart_rx_deserializer: oversampled UART receiver (start, data LSB-first, even parity, stop) feeding a
// one-entry valid/ack holding register. Define UART_RX_MAJORITY_VOTE_EN for 2-of-3 bit voting.
module uart_rx_deserializer #(
  parameter int WORD_LENGTH = 8,
  parameter int CLKRATE     = 50_000_000,
  parameter int BAUD        = 115200,
  parameter int OVERSAMPLE  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   UART_Rx_IN,
  input  logic                   UART_Rx_ACK,
  output logic [WORD_LENGTH-1:0] UART_Rx_DATA,
  output logic                   UART_Rx_VALID,
  output logic                   UART_Rx_PARITY_ERR,
  output logic                   UART_Rx_FRAME_ERR,
  output logic                   UART_Rx_OVERRUN
);

  localparam int DIV    = CLKRATE / (BAUD * OVERSAMPLE);
  localparam int DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int TCNT_W = $clog2(OVERSAMPLE);
  localparam int BCNT_W = $clog2(WORD_LENGTH + 1);
  localparam logic [TCNT_W-1:0] START_MID = TCNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TCNT_W-1:0] BIT_MID   = TCNT_W'(OVERSAMPLE - 1);

  generate
    if (DIV < 1) begin : g_div_check
      $error("uart_rx_deserializer: CLKRATE/(BAUD*OVERSAMPLE) must be >= 1");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_BREAK  = 3'd5
  } state_t;

  logic [DIV_W-1:0]       div_q;
  logic [1:0]             sync_q;
  state_t                 state_q, state_d;
  logic [TCNT_W-1:0]      tcnt_q, tcnt_d;
  logic [BCNT_W-1:0]      bcnt_q, bcnt_d;
  logic [WORD_LENGTH-1:0] shreg_q, shreg_d;
  logic                   perr_q, perr_d;
  logic                   ferr_q, ferr_d;
  logic                   deliver_q, deliver_d;
  logic [WORD_LENGTH-1:0] data_q;
  logic                   valid_q, poerr_q, foerr_q, ovr_q;

  logic                   tick;
  logic                   rxs;
  logic [TCNT_W-1:0]      mid;
  logic                   decide;
  logic                   sample;
  logic [TCNT_W-1:0]      tcnt_reload;

  assign tick = (div_q == DIV_W'(DIV - 1));
  assign rxs  = sync_q[1];
  assign mid  = (state_q == S_START) ? START_MID : BIT_MID;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q  <= '0;
      sync_q <= 2'b11;
    end else begin
      div_q  <= tick ? '0 : div_q + DIV_W'(1);
      sync_q <= {sync_q[0], UART_Rx_IN};
    end
  end

`ifdef UART_RX_MAJORITY_VOTE_EN
  // Decision lands one tick after mid; START reloads tcnt to 1 so later sample points stay put.
  localparam logic [TCNT_W-1:0] START_MID_P1 = TCNT_W'(OVERSAMPLE / 2);
  logic [1:0] vote_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vote_q <= '0;
    end else if (tick && (tcnt_q == mid - TCNT_W'(1))) begin
      vote_q[0] <= rxs;
    end else if (tick && (tcnt_q == mid)) begin
      vote_q[1] <= rxs;
    end
  end

  assign decide      = tick && (tcnt_q == ((state_q == S_START) ? START_MID_P1 : '0));
  assign sample      = (vote_q[0] & vote_q[1]) | (vote_q[0] & rxs) | (vote_q[1] & rxs);
  assign tcnt_reload = TCNT_W'(1);
`else
  assign decide      = tick && (tcnt_q == mid);
  assign sample      = rxs;
  assign tcnt_reload = '0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      tcnt_q    <= '0;
      bcnt_q    <= '0;
      shreg_q   <= '0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      deliver_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tcnt_q    <= tcnt_d;
      bcnt_q    <= bcnt_d;
      shreg_q   <= shreg_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      deliver_q <= deliver_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    tcnt_d    = tcnt_q;
    bcnt_d    = bcnt_q;
    shreg_d   = shreg_q;
    perr_d    = perr_q;
    ferr_d    = ferr_q;
    deliver_d = 1'b0;
    if (tick) begin
      tcnt_d = (tcnt_q == BIT_MID) ? '0 : tcnt_q + TCNT_W'(1);
    end
    case (state_q)
      S_IDLE: begin
        if (tick && !rxs) begin
          state_d = S_START;
          tcnt_d  = '0;
        end
      end
      S_START: begin
        if (decide) begin
          if (sample) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DATA;
            tcnt_d  = tcnt_reload;
            bcnt_d  = '0;
          end
        end
      end
      S_DATA: begin
        if (decide) begin
          shreg_d = {sample, shreg_q[WORD_LENGTH-1:1]};
          bcnt_d  = bcnt_q + BCNT_W'(1);
          if (bcnt_q == BCNT_W'(WORD_LENGTH - 1)) begin
            state_d = S_PARITY;
          end
        end
      end
      S_PARITY: begin
        if (decide) begin
          perr_d  = (^shreg_q) ^ sample;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (decide) begin
          ferr_d    = !sample;
          deliver_d = 1'b1;
          state_d   = sample ? S_IDLE : S_BREAK;
        end
      end
      S_BREAK: begin
        if (tick && rxs) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Holding register: a delivery only lands if the slot is empty or being acked this same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      poerr_q <= 1'b0;
      foerr_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else if (deliver_q) begin
      if (!valid_q || UART_Rx_ACK) begin
        data_q  <= shreg_q;
        poerr_q <= perr_q;
        foerr_q <= ferr_q;
        valid_q <= 1'b1;
        if (UART_Rx_ACK) begin
          ovr_q <= 1'b0;
        end
      end else begin
        ovr_q <= 1'b1;
      end
    end else if (UART_Rx_ACK && valid_q) begin
      valid_q <= 1'b0;
      poerr_q <= 1'b0;
      foerr_q <= 1'b0;
      ovr_q   <= 1'b0;
    end
  end

  assign UART_Rx_DATA       = data_q;
  assign UART_Rx_VALID      = valid_q;
  assign UART_Rx_PARITY_ERR = poerr_q;
  assign UART_Rx_FRAME_ERR  = foerr_q;
  assign UART_Rx_OVERRUN    = ovr_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_deserializer.sv
`default_nettype none
// Directed bench for uart_rx_deserializer at 1 tick/clk, 16 clk per bit.
module tb_uart_rx_deserializer;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_in;
  logic       ack;
  logic [7:0] data;
  logic       valid, perr, ferr, ovr;

  int checks   = 0;
  int failures = 0;

  // Clock edge (relative to frame start) of the second back-to-back delivery.
`ifdef UART_RX_MAJORITY_VOTE_EN
  localparam int         ACK_OFF    = 348;
  localparam logic [7:0] GLITCH_EXP = 8'hF0;
`else
  localparam int         ACK_OFF    = 347;
  localparam logic [7:0] GLITCH_EXP = 8'h0F;
`endif

  always #5 clk = ~clk;

  uart_rx_deserializer #(
    .WORD_LENGTH(8),
    .CLKRATE    (16_000_000),
    .BAUD       (1_000_000),
    .OVERSAMPLE (16)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .UART_Rx_IN        (rx_in),
    .UART_Rx_ACK       (ack),
    .UART_Rx_DATA      (data),
    .UART_Rx_VALID     (valid),
    .UART_Rx_PARITY_ERR(perr),
    .UART_Rx_FRAME_ERR (ferr),
    .UART_Rx_OVERRUN   (ovr)
  );

  task automatic send_bit(input logic b, input bit glitch);
    rx_in = b;
    if (glitch) begin
      repeat (8) @(negedge clk);
      rx_in = ~b;
      @(negedge clk);
      rx_in = b;
      repeat (7) @(negedge clk);
    end else begin
      repeat (16) @(negedge clk);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop, input bit glitch);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i], glitch);
    send_bit(par, 1'b0);
    send_bit(stop, 1'b0);
  endtask

  task automatic pulse_ack;
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
  endtask

  task automatic idle_gap(input int n);
    rx_in = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b0; rx_in = 1'b1; ack = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({valid, perr, ferr, ovr, data} !== 12'h000) begin
      failures++; $display("FAIL reset_outputs: got %h expected 000", {valid, perr, ferr, ovr, data});
    end
    rst = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_basic;
    send_frame(8'hA5, 1'b0, 1'b1, 1'b0);
    checks++; if (valid !== 1'b1) begin failures++; $display("FAIL basic_valid: got %b expected 1", valid); end
    checks++; if (data !== 8'hA5) begin failures++; $display("FAIL basic_data: got %h expected a5", data); end
    checks++;
    if ({perr, ferr, ovr} !== 3'b000) begin
      failures++; $display("FAIL basic_flags: got %b expected 000", {perr, ferr, ovr});
    end
    pulse_ack();
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL ack_clears_valid: got %b expected 0", valid); end
    checks++; if (data !== 8'hA5) begin failures++; $display("FAIL ack_keeps_data: got %h expected a5", data); end
    idle_gap(16);
  endtask

  task automatic test_parity;
    send_frame(8'h01, 1'b0, 1'b1, 1'b0);
    checks++; if (valid !== 1'b1) begin failures++; $display("FAIL parity_valid: got %b expected 1", valid); end
    checks++; if (data !== 8'h01) begin failures++; $display("FAIL parity_data: got %h expected 01", data); end
    checks++; if (perr !== 1'b1) begin failures++; $display("FAIL parity_err: got %b expected 1", perr); end
    checks++; if (ferr !== 1'b0) begin failures++; $display("FAIL parity_ferr: got %b expected 0", ferr); end
    pulse_ack();
    idle_gap(16);
  endtask

  task automatic test_break;
    int seen = 0;
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    checks++; if (valid !== 1'b1) begin failures++; $display("FAIL break_valid: got %b expected 1", valid); end
    checks++; if (data !== 8'h3C) begin failures++; $display("FAIL break_data: got %h expected 3c", data); end
    checks++;
    if ({perr, ferr} !== 2'b01) begin
      failures++; $display("FAIL break_flags: got %b expected 01", {perr, ferr});
    end
    pulse_ack();
    repeat (40 * 16) begin
      @(negedge clk);
      if (valid) seen++;
    end
    checks++; if (seen !== 0) begin failures++; $display("FAIL break_no_retrigger: got %0d valid cycles expected 0", seen); end
    idle_gap(32);
    send_frame(8'h81, 1'b0, 1'b1, 1'b0);
    checks++; if (data !== 8'h81) begin failures++; $display("FAIL after_break_data: got %h expected 81", data); end
    checks++;
    if ({valid, perr, ferr} !== 3'b100) begin
      failures++; $display("FAIL after_break_flags: got %b expected 100", {valid, perr, ferr});
    end
    pulse_ack();
    idle_gap(16);
  endtask

  task automatic test_back_to_back;
    send_frame(8'h11, 1'b0, 1'b1, 1'b0);
    send_frame(8'h22, 1'b0, 1'b1, 1'b0);
    checks++; if (data !== 8'h11) begin failures++; $display("FAIL overrun_data: got %h expected 11", data); end
    checks++;
    if ({valid, ovr} !== 2'b11) begin
      failures++; $display("FAIL overrun_set: got %b expected 11", {valid, ovr});
    end
    pulse_ack();
    checks++;
    if ({valid, perr, ferr, ovr} !== 4'b0000) begin
      failures++; $display("FAIL overrun_ack_clear: got %b expected 0000", {valid, perr, ferr, ovr});
    end
    idle_gap(16);
    fork
      begin
        send_frame(8'h11, 1'b0, 1'b1, 1'b0);
        send_frame(8'h22, 1'b0, 1'b1, 1'b0);
      end
      begin
        repeat (ACK_OFF) @(negedge clk);
        pulse_ack();
      end
    join
    checks++; if (data !== 8'h22) begin failures++; $display("FAIL coincident_data: got %h expected 22", data); end
    checks++;
    if ({valid, ovr} !== 2'b10) begin
      failures++; $display("FAIL coincident_flags: got %b expected 10", {valid, ovr});
    end
    pulse_ack();
    idle_gap(16);
  endtask

  task automatic test_false_start;
    rx_in = 1'b0;
    repeat (4) @(negedge clk);
    rx_in = 1'b1;
    repeat (200) @(negedge clk);
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL false_start_valid: got %b expected 0", valid); end
    send_frame(8'hC3, 1'b0, 1'b1, 1'b0);
    checks++; if (data !== 8'hC3) begin failures++; $display("FAIL false_start_realign: got %h expected c3", data); end
    pulse_ack();
    idle_gap(16);
  endtask

  task automatic test_midframe_reset;
    send_frame(8'h77, 1'b0, 1'b1, 1'b0);
    checks++; if (valid !== 1'b1) begin failures++; $display("FAIL preload_valid: got %b expected 1", valid); end
    idle_gap(16);
    for (int i = 0; i < 4; i++) send_bit(1'b0, 1'b0);
    rx_in = 1'b0;
    repeat (8) @(negedge clk);
    rst   = 1'b0;
    rx_in = 1'b1;
    #1;
    checks++;
    if ({valid, perr, ferr, ovr, data} !== 12'h000) begin
      failures++; $display("FAIL async_reset_outputs: got %h expected 000", {valid, perr, ferr, ovr, data});
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (32) @(negedge clk);
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL no_partial_word: got %b expected 0", valid); end
    send_frame(8'h5A, 1'b0, 1'b1, 1'b0);
    checks++; if (data !== 8'h5A) begin failures++; $display("FAIL post_reset_data: got %h expected 5a", data); end
    checks++;
    if ({valid, perr, ferr, ovr} !== 4'b1000) begin
      failures++; $display("FAIL post_reset_flags: got %b expected 1000", {valid, perr, ferr, ovr});
    end
    pulse_ack();
    idle_gap(16);
  endtask

  task automatic test_glitch;
    send_frame(8'hF0, 1'b0, 1'b1, 1'b1);
    checks++; if (valid !== 1'b1) begin failures++; $display("FAIL glitch_valid: got %b expected 1", valid); end
    checks++; if (data !== GLITCH_EXP) begin failures++; $display("FAIL glitch_data: got %h expected %h", data, GLITCH_EXP); end
    checks++; if (perr !== 1'b0) begin failures++; $display("FAIL glitch_perr: got %b expected 0", perr); end
    pulse_ack();
    idle_gap(16);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_break();
    test_back_to_back();
    test_false_start();
    test_midframe_reset();
    test_glitch();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
